// File: rtl/load_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard_pkg
// Description : Shared constants and helpers for the load scoreboard:
//               rd source selects, counter defaults and the "tracked write"
//               predicate used for both the issue and the retire side.
// Revision    : 1.0 - initial release
// ============================================================================
package load_scoreboard_pkg;

    // Source of the value written to rd; only MEM results cannot be forwarded
    localparam logic [1:0] RD_DATA_SEL_ALU = 2'd0;
    localparam logic [1:0] RD_DATA_SEL_PC4 = 2'd1;
    localparam logic [1:0] RD_DATA_SEL_MEM = 2'd2;

    // Counter defaults: one load each in EX, MEMPREP, MEMEX and WB
    localparam int SB_NUM_REGS     = 16;
    localparam int SB_CNT_W        = 3;
    localparam int SB_MAX_INFLIGHT = 4;

    // A write is tracked when it is a real, non-x0 write of memory data
    function automatic logic sb_tracked(
        input logic       valid,
        input logic       we,
        input logic       rd_nonzero,
        input logic [1:0] rd_data_sel
    );
        return valid && we && rd_nonzero && (rd_data_sel == RD_DATA_SEL_MEM);
    endfunction

endpackage : load_scoreboard_pkg
`default_nettype wire

// File: rtl/load_scoreboard_counter.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard_counter
// Description : Per-register up/down saturating count of loads in flight.
//               Simultaneous inc and dec cancel. err flags an inc while full
//               or a dec while empty; the count never leaves 0..MAX_INFLIGHT.
// Revision    : 1.0 - initial release
// ============================================================================
module load_scoreboard_counter
    import load_scoreboard_pkg::*;
#(
    parameter int CNT_W        = SB_CNT_W,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic pending,
    output logic err
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_count == c_max);
    assign w_empty = (r_count == '0);

    // Count in-flight loads; saturate at both ends, cancel on inc+dec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !dec && !w_full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (dec && !inc && !w_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign pending = !w_empty;
    assign err     = (inc && w_full) || (dec && w_empty);

endmodule : load_scoreboard_counter
`default_nettype wire

// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard
// Description : Tracks in-flight RV32E loads (rd_data_sel == MEM) from issue
//               to retirement and stalls ID on a read of a pending register.
//               Optional macro SCOREBOARD_STATS_EN adds stall_cycles and
//               load_issues statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = SB_NUM_REGS,
    parameter int CNT_W        = SB_CNT_W,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] rs1,
    input  logic [$clog2(NUM_REGS)-1:0] rs2,
    input  logic                        uses_rs1,
    input  logic                        uses_rs2,
    input  logic                        issue_valid,
    input  logic                        issue_we,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic [1:0]                  issue_rd_data_sel,
    input  logic                        wb_valid,
    input  logic                        wb_we,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic [1:0]                  wb_rd_data_sel,
    output logic                        stall_ID,
    output logic [NUM_REGS-1:0]         pending_mask,
    output logic                        busy,
    output logic                        sb_error
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 load_issues
`endif
);

    localparam int c_reg_w = $clog2(NUM_REGS);

    logic                w_issue_trk;
    logic                w_retire_trk;
    logic [NUM_REGS-1:0] w_pending;
    logic [NUM_REGS-1:0] w_err;
    logic                w_stall_rs1;
    logic                w_stall_rs2;
    logic                r_err;

    assign w_issue_trk  = sb_tracked(issue_valid, issue_we, issue_rd != '0, issue_rd_data_sel);
    assign w_retire_trk = sb_tracked(wb_valid, wb_we, wb_rd != '0, wb_rd_data_sel);

    // x0 is hardwired to zero and never holds a pending load
    assign w_pending[0] = 1'b0;
    assign w_err[0]     = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic w_inc;
        logic w_dec;

        assign w_inc = w_issue_trk  && (issue_rd == c_reg_w'(r));
        assign w_dec = w_retire_trk && (wb_rd    == c_reg_w'(r));

        load_scoreboard_counter #(
            .CNT_W        (CNT_W),
            .MAX_INFLIGHT (MAX_INFLIGHT)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (w_inc),
            .dec     (w_dec),
            .pending (w_pending[r]),
            .err     (w_err[r])
        );
    end

    // Stall uses registered state only, so a load issuing this cycle never
    // stalls its own issuer and the stall drops the cycle after WB
    assign w_stall_rs1 = uses_rs1 && (rs1 != '0) && w_pending[rs1];
    assign w_stall_rs2 = uses_rs2 && (rs2 != '0) && w_pending[rs2];
    assign stall_ID    = w_stall_rs1 || w_stall_rs2;

    // Sticky protocol error: counter misuse or issuing past a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((|w_err) || (issue_valid && stall_ID)) begin
            r_err <= 1'b1;
        end
    end

    assign pending_mask = w_pending;
    assign busy         = |w_pending;
    assign sb_error     = r_err;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_load_issues;

    // Free-running, wrapping statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_load_issues  <= '0;
        end else begin
            if (stall_ID) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_issue_trk) begin
                r_load_issues <= r_load_issues + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign load_issues  = r_load_issues;
`endif

endmodule : load_scoreboard
`default_nettype wire

// File: tb/tb_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_scoreboard
// Description : Self-checking bench for load_scoreboard: directed scenarios
//               with literal expectations plus a randomized phase checked
//               every cycle against a per-register count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_scoreboard;
    import load_scoreboard_pkg::*;

    localparam int NR  = 16;
    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs1 = '0, rs2 = '0, issue_rd = '0, wb_rd = '0;
    logic        uses_rs1 = 1'b0, uses_rs2 = 1'b0;
    logic        issue_valid = 1'b0, issue_we = 1'b0;
    logic        wb_valid = 1'b0, wb_we = 1'b0;
    logic [1:0]  issue_rd_data_sel = '0, wb_rd_data_sel = '0;
    logic        stall_ID, busy, sb_error;
    logic [15:0] pending_mask;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, load_issues;
`endif

    int total = 0;
    int bad   = 0;

    load_scoreboard dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rs1               (rs1),
        .rs2               (rs2),
        .uses_rs1          (uses_rs1),
        .uses_rs2          (uses_rs2),
        .issue_valid       (issue_valid),
        .issue_we          (issue_we),
        .issue_rd          (issue_rd),
        .issue_rd_data_sel (issue_rd_data_sel),
        .wb_valid          (wb_valid),
        .wb_we             (wb_we),
        .wb_rd             (wb_rd),
        .wb_rd_data_sel    (wb_rd_data_sel),
        .stall_ID          (stall_ID),
        .pending_mask      (pending_mask),
        .busy              (busy),
        .sb_error          (sb_error)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles      (stall_cycles),
        .load_issues       (load_issues)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_cnt [NR];
    bit          m_err = 1'b0;
    logic [31:0] m_stalls = '0;
    logic [31:0] m_loads  = '0;

    initial for (int r = 0; r < NR; r++) m_cnt[r] = 0;

    function automatic bit m_issue();
        return issue_valid && issue_we && issue_rd != 4'd0 && issue_rd_data_sel == RD_DATA_SEL_MEM;
    endfunction

    function automatic bit m_retire();
        return wb_valid && wb_we && wb_rd != 4'd0 && wb_rd_data_sel == RD_DATA_SEL_MEM;
    endfunction

    function automatic bit m_stall();
        return (uses_rs1 && rs1 != 4'd0 && m_cnt[rs1] > 0) ||
               (uses_rs2 && rs2 != 4'd0 && m_cnt[rs2] > 0);
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m;
        m = '0;
        for (int r = 1; r < NR; r++) m[r] = (m_cnt[r] > 0);
        return m;
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > MAX) ? MAX : v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) m_cnt[r] <= 0;
            m_err    <= 1'b0;
            m_stalls <= '0;
            m_loads  <= '0;
        end else begin
            for (int r = 1; r < NR; r++)
                m_cnt[r] <= clamp(m_cnt[r] + int'(m_issue() && issue_rd == 4'(r))
                                           - int'(m_retire() && wb_rd == 4'(r)));
            m_err <= m_err || (m_issue() && m_cnt[issue_rd] == MAX) ||
                     (m_retire() && m_cnt[wb_rd] == 0) || (issue_valid && m_stall());
            m_stalls <= m_stalls + (m_stall() ? 32'd1 : 32'd0);
            m_loads  <= m_loads + (m_issue() ? 32'd1 : 32'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("stall_ID",     {31'd0, stall_ID},  {31'd0, m_stall()});
        chk("pending_mask", {16'd0, pending_mask}, {16'd0, m_mask()});
        chk("busy",         {31'd0, busy},      {31'd0, (m_mask() != 16'd0)});
        chk("sb_error",     {31'd0, sb_error},  {31'd0, m_err});
`ifdef SCOREBOARD_STATS_EN
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("load_issues",  load_issues,  m_loads);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_rd = 0; issue_rd_data_sel = RD_DATA_SEL_ALU;
        wb_valid = 0; wb_we = 0; wb_rd = 0; wb_rd_data_sel = RD_DATA_SEL_ALU;
        uses_rs1 = 0; uses_rs2 = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic issue(input logic [3:0] rd, input logic [1:0] sel);
        issue_valid = 1; issue_we = 1; issue_rd = rd; issue_rd_data_sel = sel;
    endtask

    task automatic retire(input logic [3:0] rd, input logic [1:0] sel);
        wb_valid = 1; wb_we = 1; wb_rd = rd; wb_rd_data_sel = sel;
    endtask

    task automatic no_issue();
        issue_valid = 0; issue_we = 0;
    endtask

    task automatic no_retire();
        wb_valid = 0; wb_we = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        tick(); tick();
        chk("reset_mask", {16'd0, pending_mask}, 32'h0);
        chk("reset_err",  {31'd0, sb_error}, 32'h0);
        rst_n = 1;
        tick();

        // Load-use: stall while pending, clear the cycle after WB
        issue(4'd5, RD_DATA_SEL_MEM);
        tick();
        no_issue(); rs1 = 4'd5; uses_rs1 = 1;
        #1;
        chk("lu_stall_1", {31'd0, stall_ID}, 32'h1);
        chk("lu_mask",    {16'd0, pending_mask}, 32'h0020);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lu_stall_hold", {31'd0, stall_ID}, 32'h1);
        end
        retire(4'd5, RD_DATA_SEL_MEM);
        tick();
        no_retire();
        #1;
        chk("lu_stall_clr", {31'd0, stall_ID}, 32'h0);
        chk("lu_mask_clr",  {16'd0, pending_mask}, 32'h0);
        idle();

        // ALU producer never stalls
        issue(4'd6, RD_DATA_SEL_ALU);
        tick();
        no_issue(); rs2 = 4'd6; uses_rs2 = 1;
        #1;
        chk("alu_stall", {31'd0, stall_ID}, 32'h0);
        chk("alu_mask",  {16'd0, pending_mask}, 32'h0);
        idle();

        // Issuer reading its own rd in the same cycle is not a hazard
        issue(4'd4, RD_DATA_SEL_MEM); rs1 = 4'd4; uses_rs1 = 1;
        #1;
        chk("self_stall", {31'd0, stall_ID}, 32'h0);
        tick();
        no_issue(); retire(4'd4, RD_DATA_SEL_MEM);
        tick();
        idle();

        // Simultaneous issue+retire on x7
        issue(4'd7, RD_DATA_SEL_MEM);
        tick();
        retire(4'd7, RD_DATA_SEL_MEM);
        tick();
        no_issue();
        #1;
        chk("x7_same", {31'd0, pending_mask[7]}, 32'h1);
        tick();
        no_retire();
        #1;
        chk("x7_clr", {31'd0, pending_mask[7]}, 32'h0);
        chk("x7_err", {31'd0, sb_error}, 32'h0);
        idle();

        // x0 and uses gating
        issue(4'd0, RD_DATA_SEL_MEM);
        tick();
        issue(4'd3, RD_DATA_SEL_MEM);
        #1;
        chk("x0_mask", {16'd0, pending_mask}, 32'h0);
        tick();
        no_issue(); rs1 = 4'd3; uses_rs1 = 0;
        #1;
        chk("uses_off", {31'd0, stall_ID}, 32'h0);
        uses_rs1 = 1;
        #1;
        chk("uses_on", {31'd0, stall_ID}, 32'h1);
        tick();
        uses_rs1 = 0; retire(4'd3, RD_DATA_SEL_MEM);
        tick();
        idle();

        // Randomized, protocol-respecting traffic
        for (int c = 0; c < 400; c++) begin
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
            uses_rs1 = 1'($urandom);
            uses_rs2 = 1'($urandom);
            issue_valid = 1'($urandom);
            issue_we = 1'($urandom_range(0, 3) != 0);
            issue_rd = 4'($urandom_range(0, 15));
            issue_rd_data_sel = 2'($urandom_range(0, 3));
            if (m_stall()) issue_valid = 0;
            if (m_issue() && m_cnt[issue_rd] == MAX) issue_rd_data_sel = RD_DATA_SEL_ALU;
            wb_valid = 1'($urandom);
            wb_we = 1'($urandom_range(0, 3) != 0);
            wb_rd = 4'($urandom_range(0, 15));
            wb_rd_data_sel = 2'($urandom_range(0, 3));
            if (m_retire() && m_cnt[wb_rd] == 0) wb_rd_data_sel = RD_DATA_SEL_PC4;
            tick();
        end
        idle();

        // Asynchronous reset with a counter nonzero
        issue(4'd8, RD_DATA_SEL_MEM);
        tick();
        idle();
        rst_n = 0;
        #1;
        chk("async_mask", {16'd0, pending_mask}, 32'h0);
        chk("async_busy", {31'd0, busy}, 32'h0);
        chk("async_err",  {31'd0, sb_error}, 32'h0);
        tick();
        rst_n = 1; rs1 = 4'd5; uses_rs1 = 1;
        #1;
        chk("release_stall", {31'd0, stall_ID}, 32'h0);
        tick();
        idle();

        // Underflow error
        retire(4'd9, RD_DATA_SEL_MEM);
        tick();
        no_retire();
        #1;
        chk("unf_err",  {31'd0, sb_error}, 32'h1);
        chk("unf_mask", {16'd0, pending_mask}, 32'h0);
        do_reset();

        // Overflow: five issues saturate at four
        issue(4'd2, RD_DATA_SEL_MEM);
        for (int i = 0; i < 5; i++) tick();
        no_issue();
        #1;
        chk("ovf_err",  {31'd0, sb_error}, 32'h1);
        chk("ovf_mask", {16'd0, pending_mask}, 32'h0004);
`ifdef SCOREBOARD_STATS_EN
        chk("ovf_loads", load_issues, 32'd5);
`endif
        retire(4'd2, RD_DATA_SEL_MEM);
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("sat_hold", {31'd0, pending_mask[2]}, 32'h1);
        tick();
        no_retire();
        #1;
        chk("sat_drain", {31'd0, pending_mask[2]}, 32'h0);

        // Stall-issue error, issue still tracked
        do_reset();
        issue(4'd10, RD_DATA_SEL_MEM);
        tick();
        issue(4'd11, RD_DATA_SEL_MEM); rs1 = 4'd10; uses_rs1 = 1;
        tick();
        idle();
        #1;
        chk("si_err",  {31'd0, sb_error}, 32'h1);
        chk("si_mask", {16'd0, pending_mask}, 32'h0C00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_load_scoreboard
`default_nettype wire
